// File: rtl/rca_operand_loader_pkg.sv
// Shared types for the byte-serial operand loader in front of rca_clk.
package rca_operand_loader_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Byte-index width; kept at least 1 so a single-byte operand still elaborates.
  function automatic int idx_w(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/rca_operand_loader_if.sv
// Operand byte stream in, captured result out; the loader sits on the slave side.
interface rca_operand_loader_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_ci;
  logic [WIDTH-1:0] res_s;
  logic             res_co;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output in_data, in_valid, in_ci, res_ready,
    input  in_ready, res_s, res_co, res_valid
  );

  modport slave (
    input  in_data, in_valid, in_ci, res_ready,
    output in_ready, res_s, res_co, res_valid
  );
endinterface

// File: rtl/rca_operand_loader_byte_assembler.sv
// Little-endian operand register: writes byte idx of q on load, clears on clr.
module rca_operand_loader_byte_assembler
  import rca_operand_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] q
);
  localparam int NBYTES = WIDTH / 8;

  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    always_ff @(posedge clk) begin
      if (clr)
        q[8*k +: 8] <= 8'h00;
      else if (load && idx == IDX_W'(k))
        q[8*k +: 8] <= data;
    end
  end
endmodule

// File: rtl/rca_operand_loader.sv
// Assembles A then B from a byte stream, holds them on rca_clk, waits out the
// adder latency and presents s/co on a valid/ready result port.
module rca_operand_loader
  import rca_operand_loader_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rca_operand_loader_if.slave   io,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_ci,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_co,
  output logic                  busy
);
  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W  = idx_w(WIDTH);
  localparam int LAT_W  = $clog2(ADD_LAT + 1) + 1;

  state_t           state;
  logic [IDX_W-1:0] byte_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [WIDTH-1:0] res_s;
  logic             res_co;
  logic             res_valid;
  logic             in_ready;
  logic             xfer;
  logic             last_byte;

  assign in_ready  = !rst && (state == LOAD_A || state == LOAD_B);
  assign busy      = !rst && (state == WAIT || state == DONE);
  assign xfer      = io.in_valid && in_ready;
  assign last_byte = (byte_cnt == IDX_W'(NBYTES - 1));

  assign io.in_ready  = in_ready;
  assign io.res_s     = res_s;
  assign io.res_co    = res_co;
  assign io.res_valid = res_valid;

  rca_operand_loader_byte_assembler #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_asm_a (
    .clk  (clk),
    .clr  (rst),
    .load (xfer && state == LOAD_A),
    .idx  (byte_cnt),
    .data (io.in_data),
    .q    (add_a)
  );

  rca_operand_loader_byte_assembler #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_asm_b (
    .clk  (clk),
    .clr  (rst),
    .load (xfer && state == LOAD_B),
    .idx  (byte_cnt),
    .data (io.in_data),
    .q    (add_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      byte_cnt  <= '0;
      lat_cnt   <= '0;
      add_ci    <= 1'b0;
      res_s     <= '0;
      res_co    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (xfer) begin
          if (last_byte) begin
            state    <= LOAD_B;
            byte_cnt <= '0;
          end else
            byte_cnt <= byte_cnt + IDX_W'(1);
        end
        LOAD_B: if (xfer) begin
          if (last_byte) begin
            add_ci   <= io.in_ci;
            state    <= WAIT;
            lat_cnt  <= '0;
            byte_cnt <= '0;
          end else
            byte_cnt <= byte_cnt + IDX_W'(1);
        end
        // s/co are trustworthy once ADD_LAT edges have passed with stable inputs
        WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_W'(ADD_LAT)) begin
            res_s     <= add_s;
            res_co    <= add_co;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (io.res_ready) begin
          res_valid <= 1'b0;
          byte_cnt  <= '0;
          state     <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_operand_loader.sv
// Loader driven byte-serially into a behavioural registered 32-bit adder.
module tb_rca_operand_loader;
  localparam int WIDTH   = 32;
  localparam int ADD_LAT = 1;
  localparam int STEP    = 10;

  logic clk = 1'b0;
  logic rst;
  always #(STEP/2) clk = ~clk;

  rca_operand_loader_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_ci, add_co, busy;

  rca_operand_loader #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io     (bus),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_ci (add_ci),
    .add_s  (add_s),
    .add_co (add_co),
    .busy   (busy)
  );

  // rca_clk stand-in: one registered stage
  always @(posedge clk)
    {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic ci, input bit gap);
    int n = 0;
    bus.in_data  = d;
    bus.in_ci    = ci;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    if (gap) @(negedge clk);
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8], 1'b0, gap);
    for (int k = 0; k < 4; k++) send_byte(b[8*k +: 8], ci, (k < 3) ? gap : 1'b0);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] s, input logic co);
    int n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_s"}, bus.res_s, s);
    chk({tag, "_co"}, bus.res_co, co);
  endtask

  task automatic take_result(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_released"}, bus.res_valid, 0);
    chk({tag, "_ready_again"}, bus.in_ready, 1);
  endtask

  initial begin
    #(STEP * 5000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_ci     = 1'b0;
    bus.res_ready = 1'b0;

    // 1: reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_s", bus.res_s, 0);
    chk("rst_res_co", bus.res_co, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_ci", add_ci, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // 2: carry ripples through every bit; exact latency
    send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    chk("t2_add_a", add_a, 32'hFFFF_FFFF);
    chk("t2_add_ci", add_ci, 1);
    chk("t2_busy", busy, 1);
    chk("t2_in_ready_wait", bus.in_ready, 0);
    chk("t2_lat0", bus.res_valid, 0);
    @(negedge clk);
    chk("t2_lat1", bus.res_valid, 0);
    @(negedge clk);
    chk("t2_lat2", bus.res_valid, 1);
    wait_result("t2", 32'h0000_0000, 1'b1);
    take_result("t2");

    // 3
    send_op(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);
    wait_result("t3", 32'hFFFF_FFFF, 1'b0);
    take_result("t3");

    // 4: byte ordering with in_valid gaps
    send_op(32'h135F_A562, 32'h3561_4642, 1'b0, 1'b1);
    chk("t4_add_a", add_a, 32'h135F_A562);
    chk("t4_add_b", add_b, 32'h3561_4642);
    wait_result("t4", 32'h48C0_EBA4, 1'b0);
    take_result("t4");

    // 5: result backpressure, byte offered in DONE must stay put
    send_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_result("t5", 32'h0000_0001, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.res_valid, 1);
      chk("t5_hold_s", bus.res_s, 32'h0000_0001);
      chk("t5_hold_co", bus.res_co, 1);
      chk("t5_in_ready", bus.in_ready, 0);
    end
    chk("t5_add_a_untouched", add_a, 32'h8000_0000);
    bus.in_valid = 1'b0;
    take_result("t5");
    chk("t5_add_a_held", add_a, 32'h8000_0000);
    chk("t5_add_ci_held", add_ci, 1);

    // 6: reset mid-B, then a fresh op
    for (int k = 0; k < 4; k++) send_byte(8'h11 * (k + 1), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'h55, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_add_a", add_a, 0);
    chk("t6_add_b", add_b, 0);
    chk("t6_in_ready_rst", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    send_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    wait_result("t6", 32'h0000_0001, 1'b0);
    take_result("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
